// File: rtl/ddr_page_reader_if.sv
// ----------------------------------------------------------------------------
// ddr_page_reader_if
//   Bundles the cache-controller page-request port and the MIG-style DDR
//   user-interface read port of ddr_page_reader.
//
//   Signals (direction seen from the reader, i.e. the slave modport):
//     ddr_ctrl_addr      in   32        CPU byte address of the requested page
//     ddr_ctrl_re        in   1         page read request (level)
//     ddr_ctrl_data_read out  PAGE_W    assembled page, beat k at [k*BEAT_W +: BEAT_W]
//     ddr_ctrl_read_end  out  1         page complete
//     app_addr           out  APP_AW    DDR command byte address
//     app_cmd            out  3         DDR command (always read)
//     app_en             out  1         DDR command valid
//     app_rdy            in   1         DDR command accepted
//     app_rd_data        in   BEAT_W    returned read beat
//     app_rd_data_valid  in   1         returned beat valid
//     busy               out  1         a page fetch is in progress or completing
//
//   slave  : the page reader itself
//   master : the environment (cache controller + DDR core)
// ----------------------------------------------------------------------------
interface ddr_page_reader_if #(
    parameter int BEAT_W = 128,
    parameter int BEATS  = 32,
    parameter int APP_AW = 27
);
    logic [31:0]             ddr_ctrl_addr;
    logic                    ddr_ctrl_re;
    logic [BEAT_W*BEATS-1:0] ddr_ctrl_data_read;
    logic                    ddr_ctrl_read_end;
    logic [APP_AW-1:0]       app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    logic [BEAT_W-1:0]       app_rd_data;
    logic                    app_rd_data_valid;
    logic                    busy;

    modport slave (
        input  ddr_ctrl_addr,
        input  ddr_ctrl_re,
        output ddr_ctrl_data_read,
        output ddr_ctrl_read_end,
        output app_addr,
        output app_cmd,
        output app_en,
        input  app_rdy,
        input  app_rd_data,
        input  app_rd_data_valid,
        output busy
    );

    modport master (
        output ddr_ctrl_addr,
        output ddr_ctrl_re,
        input  ddr_ctrl_data_read,
        input  ddr_ctrl_read_end,
        input  app_addr,
        input  app_cmd,
        input  app_en,
        output app_rdy,
        output app_rd_data,
        output app_rd_data_valid,
        input  busy
    );
endinterface

// File: rtl/ddr_page_reader.sv
// ----------------------------------------------------------------------------
// ddr_page_reader
//   Serves one page read for the cache controller: on a request it issues
//   BEATS read commands of BEAT_W bits each to a MIG-style DDR user interface,
//   stores the returned beats (which arrive in command order) into a page
//   register and raises ddr_ctrl_read_end until the requester drops its
//   request.
//
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  synchronous, active-low reset
//     io     ddr_page_reader_if.slave (request port + DDR user-interface port)
//
//   The page register is only rewritten beat-by-beat by the next request, so
//   its contents stay constant from completion until the next fetch's first
//   beat lands.
// ----------------------------------------------------------------------------
module ddr_page_reader #(
    parameter int BEAT_W = 128,
    parameter int BEATS  = 32,
    parameter int APP_AW = 27
) (
    input  logic               clk,
    input  logic               reset,
    ddr_page_reader_if.slave   io
);

    localparam int PAGE_W     = BEAT_W * BEATS;
    localparam int PAGE_BYTES = PAGE_W / 8;
    localparam int CNT_W      = $clog2(BEATS + 1);
    localparam int IDX_W      = $clog2(BEATS);
    localparam int BEAT_SH    = $clog2(BEAT_W / 8);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    // Only the bits that reach app_addr are kept; higher CPU address bits
    // lie outside the DDR address space.
    logic [APP_AW-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [PAGE_W-1:0] page_q;

    logic              accept;
    logic              capture;
    logic [IDX_W-1:0]  wr_idx;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        accept     = (state_q == S_ISSUE) && io.app_rdy;
        // Beats are captured while commands are outstanding; anything seen in
        // IDLE or DONE is ignored. The count guard keeps a stray extra beat
        // from wrapping into beat 0.
        capture    = ((state_q == S_ISSUE) || (state_q == S_WAIT_DATA)) &&
                     io.app_rd_data_valid && (beat_cnt_q != CNT_FULL);
        wr_idx     = beat_cnt_q[IDX_W-1:0];

        state_d    = state_q;
        base_d     = base_q;
        cmd_cnt_d  = cmd_cnt_q  + CNT_W'(accept);
        beat_cnt_d = beat_cnt_q + CNT_W'(capture);

        unique case (state_q)
            S_IDLE: begin
                if (io.ddr_ctrl_re) begin
                    base_d     = io.ddr_ctrl_addr[APP_AW-1:0] & ~APP_AW'(PAGE_BYTES - 1);
                    cmd_cnt_d  = '0;
                    beat_cnt_d = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // With zero return latency the final beat can land together
                // with the final command; go straight to DONE in that case so
                // completion still follows the last captured beat by one cycle.
                if (accept && (cmd_cnt_q == CNT_LAST)) begin
                    state_d = (beat_cnt_d == CNT_FULL) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (beat_cnt_d == CNT_FULL) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!io.ddr_ctrl_re) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cmd_cnt_q  <= '0;
            beat_cnt_q <= '0;
            page_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cmd_cnt_q  <= cmd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            if (capture) begin
                page_q[wr_idx*BEAT_W +: BEAT_W] <= io.app_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decode of the registered state
    // ------------------------------------------------------------------
    assign io.app_cmd            = 3'b001;
    assign io.app_en             = (state_q == S_ISSUE);
    assign io.app_addr           = (state_q == S_ISSUE)
                                   ? base_q + (APP_AW'(cmd_cnt_q) << BEAT_SH)
                                   : '0;
    assign io.ddr_ctrl_read_end  = (state_q == S_DONE);
    assign io.busy               = (state_q != S_IDLE);
    assign io.ddr_ctrl_data_read = page_q;

endmodule

// File: tb/tb_ddr_page_reader.sv
// ----------------------------------------------------------------------------
// tb_ddr_page_reader
//   Drives page requests into ddr_page_reader through its interface while a
//   DDR responder process accepts commands (with a chosen app_rdy pattern)
//   and returns beats after a fixed latency. Expected pages are built from
//   the address->data rule below and compared with the assembled page.
// ----------------------------------------------------------------------------
module tb_ddr_page_reader;

    localparam int BEAT_W = 128;
    localparam int BEATS  = 32;
    localparam int APP_AW = 27;
    localparam int PAGE_W = BEAT_W * BEATS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ddr_page_reader_if #(.BEAT_W(BEAT_W), .BEATS(BEATS), .APP_AW(APP_AW)) io ();

    ddr_page_reader #(.BEAT_W(BEAT_W), .BEATS(BEATS), .APP_AW(APP_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int checks = 0;
    int errors = 0;

    // Responder controls / observations
    int                 cyc        = 0;
    int                 lat        = 0;
    int                 rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: random
    logic [31:0]        salt       = '0;
    int                 beats_sent = 0;
    logic [APP_AW-1:0]  acc_log[$];

    typedef struct {
        int                due;
        logic [APP_AW-1:0] addr;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          rmode;
        int          drop;      // cycle at which re is dropped, 0 = hold
        logic [31:0] salt;
        logic [31:0] exp_base;
        int          exp_end;   // cycle read_end first high, 0 = unchecked
    } vec_t;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Data the DDR returns for a byte address: beat index in the page,
    // scrambled by a per-request salt (salt 0 gives {4{k}}).
    function automatic logic [BEAT_W-1:0] beat_data(input logic [31:0] addr, input logic [31:0] s);
        logic [31:0] k;
        k = {27'd0, addr[8:4]};
        return {k ^ s, k ^ (s * 32'd3), k ^ (s * 32'd5), k ^ (s * 32'd7)};
    endfunction

    // Expected page: beat k holds the data stored at page base + 16*k.
    function automatic logic [PAGE_W-1:0] model_page(input logic [31:0] base, input logic [31:0] s);
        logic [PAGE_W-1:0] p;
        p = '0;
        for (int k = 0; k < BEATS; k++) begin
            p[k*BEAT_W +: BEAT_W] = beat_data(base + 32'(k * 16), s);
        end
        return p;
    endfunction

    task automatic chk_page(input string name, input logic [PAGE_W-1:0] exp);
        int idx;
        idx = 0;
        for (int k = 0; k < BEATS; k++) begin
            if (io.ddr_ctrl_data_read[k*BEAT_W +: BEAT_W] !== exp[k*BEAT_W +: BEAT_W]) begin
                idx = k;
                break;
            end
        end
        chk($sformatf("%s[beat%0d]", name, idx),
            io.ddr_ctrl_data_read[idx*BEAT_W +: BEAT_W], exp[idx*BEAT_W +: BEAT_W]);
    endtask

    // ------------------------------------------------------------------
    // DDR responder: acts 1 time unit after each falling edge
    // ------------------------------------------------------------------
    initial begin
        logic              rdy;
        logic              stall;
        logic [APP_AW-1:0] stall_addr;
        pend_t             p;
        rdy        = 1'b0;
        stall      = 1'b0;
        stall_addr = '0;
        io.app_rdy           = 1'b0;
        io.app_rd_data       = '0;
        io.app_rd_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset) begin
                pend.delete();
                stall                = 1'b0;
                io.app_rdy           = 1'b0;
                io.app_rd_data_valid = 1'b0;
            end else begin
                if (stall && io.app_en) chk("addr_stable", io.app_addr, stall_addr);
                case (rdy_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ~rdy;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                io.app_rdy = rdy;
                stall      = io.app_en && !rdy;
                stall_addr = io.app_addr;
                if (io.app_en && rdy) begin
                    acc_log.push_back(io.app_addr);
                    pend.push_back('{cyc + lat, io.app_addr});
                end
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    p = pend.pop_front();
                    io.app_rd_data_valid = 1'b1;
                    io.app_rd_data       = beat_data({5'd0, p.addr}, salt);
                    beats_sent++;
                end else begin
                    // Junk beats while idle must be ignored by the reader.
                    io.app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
                    io.app_rd_data_valid = !io.busy && ($urandom_range(0, 1) == 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One complete page request with completion handshake
    // ------------------------------------------------------------------
    task automatic run_req(input string tag, input logic [31:0] addr, input int l, input int rm,
                           input int drop, input logic [31:0] s, input logic [31:0] exp_base,
                           input int exp_end);
        int                n;
        bit                seen;
        bit                busy_ok;
        int                bad;
        logic [PAGE_W-1:0] ep;
        logic [APP_AW-1:0] ea;
        @(negedge clk);
        lat      = l;
        rdy_mode = rm;
        salt     = s;
        acc_log.delete();
        beats_sent = 0;
        io.ddr_ctrl_addr = addr;
        io.ddr_ctrl_re   = 1'b1;
        n       = 0;
        seen    = 0;
        busy_ok = 1;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (drop > 0 && n == drop) io.ddr_ctrl_re = 1'b0;
            if (io.ddr_ctrl_read_end) seen = 1;
            else if (!io.busy) busy_ok = 0;
        end
        chk({tag, "_read_end_seen"}, 128'(seen), 128'(1));
        if (exp_end > 0) chk({tag, "_read_end_cycle"}, 128'(n), 128'(exp_end));
        chk({tag, "_busy_during"}, 128'(busy_ok), 128'(1));
        chk({tag, "_busy_done"}, 128'(io.busy), 128'(1));
        ep = model_page(exp_base, s);
        chk_page({tag, "_page"}, ep);
        chk({tag, "_cmd_count"}, 128'(acc_log.size()), 128'(BEATS));
        bad = -1;
        for (int i = 0; i < acc_log.size() && i < BEATS; i++) begin
            ea = APP_AW'(exp_base + 32'(16 * i));
            if (bad < 0 && acc_log[i] !== ea) bad = i;
        end
        if (bad < 0) bad = 0;
        ea = APP_AW'(exp_base + 32'(16 * bad));
        chk($sformatf("%s_app_addr[%0d]", tag, bad),
            (acc_log.size() > bad) ? 128'(acc_log[bad]) : 128'hX, 128'(ea));
        if (!io.ddr_ctrl_re) begin
            @(negedge clk);
            chk({tag, "_read_end_pulse"}, 128'(io.ddr_ctrl_read_end), 128'(0));
        end else begin
            @(negedge clk);
            chk({tag, "_read_end_hold"}, 128'(io.ddr_ctrl_read_end), 128'(1));
            io.ddr_ctrl_re = 1'b0;
            @(negedge clk);
            chk({tag, "_read_end_drop"}, 128'(io.ddr_ctrl_read_end), 128'(0));
        end
        chk({tag, "_busy_idle"}, 128'(io.busy), 128'(0));
        @(negedge clk);
        chk_page({tag, "_page_hold"}, ep);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_end"}, 128'(io.ddr_ctrl_read_end), 128'(0));
        chk({tag, "_app_en"},   128'(io.app_en),            128'(0));
        chk({tag, "_app_addr"}, 128'(io.app_addr),          128'(0));
        chk({tag, "_busy"},     128'(io.busy),              128'(0));
        chk({tag, "_app_cmd"},  128'(io.app_cmd),           128'(3'b001));
        chk_page({tag, "_page"}, '0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t        vecs[5];
        logic [31:0] a;
        logic [31:0] s;
        int          l;
        int          rm;
        int          dr;
        int          n;

        vecs[0] = '{32'h0000_1234, 4, 0, 0, 32'h0000_0000, 32'h0000_1200, 37}; // basic
        vecs[1] = '{32'h0000_05FF, 0, 0, 0, 32'h1111_0011, 32'h0000_0400, 33}; // overlap L=0
        vecs[2] = '{32'h0ABC_DE42, 3, 1, 0, 32'hC0DE_0042, 32'h0ABC_DE00, 0};  // backpressure
        vecs[3] = '{32'h2000_0010, 3, 0, 5, 32'h5A5A_0003, 32'h2000_0000, 36}; // early re drop
        vecs[4] = '{32'hFFFF_FFFF, 2, 0, 0, 32'h0F0F_F0F0, 32'hFFFF_FE00, 35}; // top of space

        io.ddr_ctrl_addr = '0;
        io.ddr_ctrl_re   = 1'b0;
        reset            = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_page("idle_junk_ignored", '0);

        for (int i = 0; i < 5; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].rmode,
                    vecs[i].drop, vecs[i].salt, vecs[i].exp_base, vecs[i].exp_end);
        end

        // Reset after 10 beats of a transfer
        @(negedge clk);
        lat = 2; rdy_mode = 0; salt = 32'hDEAD_0001; beats_sent = 0; acc_log.delete();
        io.ddr_ctrl_addr = 32'h0000_3000;
        io.ddr_ctrl_re   = 1'b1;
        n = 0;
        while (beats_sent < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_10_beats", 128'(beats_sent >= 10), 128'(1));
        reset          = 1'b0;
        io.ddr_ctrl_re = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        reset = 1'b1;
        run_req("after_rst", 32'h0000_0200, 4, 0, 0, 32'h0BAD_CAFE, 32'h0000_0200, 37);

        // Back-to-back pages; second request one cycle after IDLE
        run_req("b2b_a", 32'h0000_0400, 1, 0, 0, 32'hAAAA_0001, 32'h0000_0400, 34);
        run_req("b2b_b", 32'h0000_0600, 1, 0, 0, 32'h5555_0002, 32'h0000_0600, 34);

        // Randomized requests
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            s  = $urandom;
            l  = $urandom_range(0, 6);
            rm = $urandom_range(0, 2);
            dr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
            run_req($sformatf("rnd%0d", i), a, l, rm, dr, s,
                    a - (a % 32'd512), (rm == 0) ? (33 + l) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
